fetch_pc: RTL and testbench
===========================

FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: reset  input  1  synchronous, active-high reset.
REQ-003: NPC  input  32  next fetch address from next-PC logic; sampled every non-stalled, non-redirected edge.
REQ-004: Stall_IF  input  1  1 = hold fetch address and delay-slot flag this edge.
REQ-005: Req  input  1  exception/interrupt taken; 1 = redirect fetch to handler entry.
REQ-006: ID_Is_Jump  input  1  instruction in ID is a branch/jump; the next fetched instruction is its delay slot.
REQ-007: IF_PC  output  32  current fetch address (registered).
REQ-008: IF_BD  output  1  instruction at IF_PC is a delay slot (registered).
REQ-009: IF_Exc  output  1  fetch exception flag for IF_PC (combinational from IF_PC).
REQ-010: IF_ExcCode  output  5  fetch exception code; 5'd4 (AdEL) when IF_Exc=1, else 5'd0.
REQ-011: State  output  2  FSM state: 2'd0 RUN, 2'd1 STALL, 2'd2 EXC.
REQ-012: Fetch_Cnt, Stall_Cnt  output  32 each  performance counters; present only per REQ-027.

Function
REQ-013: Priority per edge SHALL be reset > Req > Stall_IF > normal advance.
REQ-014: Normal advance: IF_PC <= NPC, IF_BD <= ID_Is_Jump, State <= RUN; latency one cycle NPC -> IF_PC.
REQ-015: Stall (Req=0, Stall_IF=1): IF_PC and IF_BD hold; State <= STALL; any number of consecutive stall cycles allowed.
REQ-016: STALL -> RUN on first edge with Stall_IF=0 and Req=0; IF_PC <= NPC sampled at that edge.
REQ-017: Req=1 (any state, regardless of Stall_IF): IF_PC <= 32'h0000_4180, IF_BD <= 0, State <= EXC.
REQ-018: EXC lasts until next edge; from EXC, transitions identical to RUN (REQ-014/015/017); Req in consecutive cycles keeps IF_PC=0x4180, State=EXC.
REQ-019: IF_Exc=1 iff IF_PC[1:0]!=0 or IF_PC < 32'h0000_3000 or IF_PC > 32'h0000_6FFC; unsigned compare, full 32 bits.
REQ-020: Erroneous IF_PC SHALL NOT alter sequencing; block still advances to NPC (downstream converts instruction to nop).
REQ-021: State encoding 2'd3 unreachable; if ever present, next edge behaves as RUN.

Reset
REQ-022: reset=1 at an edge: IF_PC <= 32'h0000_3000, IF_BD <= 0, State <= RUN, counters <= 0; overrides Req and Stall_IF.
REQ-023: Reset asserted mid-stall or mid-EXC SHALL take effect at that edge with no residual state.
REQ-024: After reset, IF_Exc=0 and IF_ExcCode=0 (0x3000 is legal).

Configuration
REQ-025: Macro FETCH_PERF_CNT_EN controls performance counters.
REQ-026: Defined: Fetch_Cnt +1 on each normal-advance edge (REQ-014); Stall_Cnt +1 on each stall edge (REQ-015); neither counts reset or Req edges; both wrap 32'hFFFF_FFFF -> 0.
REQ-027: Undefined: Fetch_Cnt/Stall_Cnt ports and logic absent; all other behaviour identical.

Verification
REQ-028: reset 1 cycle then NPC=0x3004, no stall -> IF_PC=0x3000 during reset release cycle, 0x3004 next cycle, State=RUN.
REQ-029: IF_PC=0x3008, Stall_IF=1 for 3 cycles with NPC changing -> IF_PC stays 0x3008, State=STALL, Stall_Cnt +3; Stall_IF=0 with NPC=0x300C -> IF_PC=0x300C next edge.
REQ-030: Req=1 and Stall_IF=1 together, ID_Is_Jump=1 -> IF_PC=0x4180, IF_BD=0, State=EXC; next edge NPC=0x4184 -> IF_PC=0x4184, State=RUN.
REQ-031: ID_Is_Jump=1 with NPC=0x3010 -> IF_BD=1 at IF_PC=0x3010; stall next cycle -> IF_BD remains 1.
REQ-032: NPC=0x3002 -> IF_Exc=1, IF_ExcCode=4; NPC=0x7000 -> IF_Exc=1; NPC=0x6FFC -> IF_Exc=0; NPC=0x2FFC -> IF_Exc=1.
REQ-033: FETCH_PERF_CNT_EN defined, Fetch_Cnt forced near 0xFFFF_FFFF via run of advances -> wraps to 0; reset mid-run -> both counters 0.

Source files
------------

// File: rtl/fetch_pc.sv
// Fetch-stage program counter with delay-slot flag, exception redirect and fetch address check.
// Define FETCH_PERF_CNT_EN to add the Fetch_Cnt/Stall_Cnt performance counters.
`timescale 1ns/1ps
module fetch_pc (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] NPC,
    input  logic        Stall_IF,
    input  logic        Req,
    input  logic        ID_Is_Jump,
    output logic [31:0] IF_PC,
    output logic        IF_BD,
    output logic        IF_Exc,
    output logic [4:0]  IF_ExcCode,
    output logic [1:0]  State
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] Fetch_Cnt,
    output logic [31:0] Stall_Cnt
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        EXC   = 2'd2,
        DEAD  = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO    = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI    = 32'h0000_6FFC;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_nxt;
    logic        bd_nxt;
    logic        advance;
    logic        stalling;

    // Every state, including the unreachable one, shares the same edge priorities,
    // so the next state depends only on Req and Stall_IF.
    always_comb begin
        state_nxt = RUN;
        pc_nxt    = NPC;
        bd_nxt    = ID_Is_Jump;
        advance   = 1'b1;
        stalling  = 1'b0;
        if (Req) begin
            state_nxt = EXC;
            pc_nxt    = HANDLER_PC;
            bd_nxt    = 1'b0;
            advance   = 1'b0;
        end else if (Stall_IF) begin
            state_nxt = STALL;
            pc_nxt    = IF_PC;
            bd_nxt    = IF_BD;
            advance   = 1'b0;
            stalling  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            IF_PC <= RESET_PC;
            IF_BD <= 1'b0;
        end else begin
            state <= state_nxt;
            IF_PC <= pc_nxt;
            IF_BD <= bd_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Counters wrap naturally at 32 bits; reset and redirect edges are not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            Fetch_Cnt <= 32'd0;
            Stall_Cnt <= 32'd0;
        end else begin
            if (advance)  Fetch_Cnt <= Fetch_Cnt + 32'd1;
            if (stalling) Stall_Cnt <= Stall_Cnt + 32'd1;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = advance ^ stalling;
`endif

    assign State      = state;
    assign IF_Exc     = (IF_PC[1:0] != 2'b00) || (IF_PC < TEXT_LO) || (IF_PC > TEXT_HI);
    assign IF_ExcCode = IF_Exc ? 5'd4 : 5'd0;

endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc: directed scenarios plus randomized traffic vs. a reference model.
`timescale 1ns/1ps
module tb_fetch_pc;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] NPC;
    logic        Stall_IF;
    logic        Req;
    logic        ID_Is_Jump;
    logic [31:0] IF_PC;
    logic        IF_BD;
    logic        IF_Exc;
    logic [4:0]  IF_ExcCode;
    logic [1:0]  State;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] Fetch_Cnt;
    logic [31:0] Stall_Cnt;
`endif

    fetch_pc dut (
        .clk(clk), .reset(reset), .NPC(NPC), .Stall_IF(Stall_IF), .Req(Req),
        .ID_Is_Jump(ID_Is_Jump), .IF_PC(IF_PC), .IF_BD(IF_BD), .IF_Exc(IF_Exc),
        .IF_ExcCode(IF_ExcCode), .State(State)
`ifdef FETCH_PERF_CNT_EN
        , .Fetch_Cnt(Fetch_Cnt), .Stall_Cnt(Stall_Cnt)
`endif
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_bd;
    logic [1:0]  m_st;
    logic [31:0] m_fc;
    logic [31:0] m_sc;

    function automatic logic model_exc(input logic [31:0] pc);
        return !(pc % 4 == 0 && pc >= 32'h3000 && pc <= 32'h6FFC);
    endfunction

    // Apply one edge's inputs, clock once, advance the model, sample 1ns after the edge.
    task automatic step(input logic r, input logic [31:0] npc, input logic stall,
                        input logic req, input logic jmp);
        reset = r; NPC = npc; Stall_IF = stall; Req = req; ID_Is_Jump = jmp;
        @(posedge clk);
        if (r) begin
            m_pc = 32'h3000; m_bd = 1'b0; m_st = 2'd0; m_fc = 0; m_sc = 0;
        end else if (req) begin
            m_pc = 32'h4180; m_bd = 1'b0; m_st = 2'd2;
        end else if (stall) begin
            m_st = 2'd1; m_sc = m_sc + 1;
        end else begin
            m_pc = npc; m_bd = jmp; m_st = 2'd0; m_fc = m_fc + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        compared++; if (IF_PC !== 32'h3000) begin mismatched++; $display("FAIL reset_pc: got %h want 00003000", IF_PC); end
        compared++; if (IF_BD !== 1'b0) begin mismatched++; $display("FAIL reset_bd: got %b want 0", IF_BD); end
        compared++; if (State !== 2'd0) begin mismatched++; $display("FAIL reset_state: got %0d want 0", State); end
        compared++; if (IF_Exc !== 1'b0 || IF_ExcCode !== 5'd0) begin mismatched++; $display("FAIL reset_exc: got %b/%0d want 0/0", IF_Exc, IF_ExcCode); end
`ifdef FETCH_PERF_CNT_EN
        compared++; if (Fetch_Cnt !== 0 || Stall_Cnt !== 0) begin mismatched++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", Fetch_Cnt, Stall_Cnt); end
`endif
        step(1'b0, 32'h3004, 1'b0, 1'b0, 1'b0);
        compared++; if (IF_PC !== 32'h3004) begin mismatched++; $display("FAIL first_advance: got %h want 00003004", IF_PC); end
        compared++; if (State !== 2'd0) begin mismatched++; $display("FAIL first_state: got %0d want 0", State); end
    endtask

    task automatic test_stall();
        logic [31:0] sc0;
        step(1'b0, 32'h3008, 1'b0, 1'b0, 1'b0);
        sc0 = m_sc;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h3100 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
            compared++; if (IF_PC !== 32'h3008) begin mismatched++; $display("FAIL stall_pc[%0d]: got %h want 00003008", i, IF_PC); end
            compared++; if (State !== 2'd1) begin mismatched++; $display("FAIL stall_state[%0d]: got %0d want 1", i, State); end
        end
`ifdef FETCH_PERF_CNT_EN
        compared++; if (Stall_Cnt !== sc0 + 3) begin mismatched++; $display("FAIL stall_cnt: got %0d want %0d", Stall_Cnt, sc0 + 3); end
`else
        if (sc0 + 3 != m_sc) $display("model stall count drift");
`endif
        step(1'b0, 32'h300C, 1'b0, 1'b0, 1'b0);
        compared++; if (IF_PC !== 32'h300C || State !== 2'd0) begin mismatched++; $display("FAIL stall_release: got %h/%0d want 0000300c/0", IF_PC, State); end
    endtask

    task automatic test_exc();
        step(1'b0, 32'h3500, 1'b1, 1'b1, 1'b1);
        compared++; if (IF_PC !== 32'h4180 || IF_BD !== 1'b0 || State !== 2'd2) begin mismatched++; $display("FAIL exc_enter: got %h/%b/%0d want 00004180/0/2", IF_PC, IF_BD, State); end
        step(1'b0, 32'h3600, 1'b0, 1'b1, 1'b0);
        compared++; if (IF_PC !== 32'h4180 || State !== 2'd2) begin mismatched++; $display("FAIL exc_repeat: got %h/%0d want 00004180/2", IF_PC, State); end
        step(1'b0, 32'h4184, 1'b0, 1'b0, 1'b0);
        compared++; if (IF_PC !== 32'h4184 || State !== 2'd0) begin mismatched++; $display("FAIL exc_leave: got %h/%0d want 00004184/0", IF_PC, State); end
    endtask

    task automatic test_delay_slot();
        step(1'b0, 32'h3010, 1'b0, 1'b0, 1'b1);
        compared++; if (IF_PC !== 32'h3010 || IF_BD !== 1'b1) begin mismatched++; $display("FAIL bd_set: got %h/%b want 00003010/1", IF_PC, IF_BD); end
        step(1'b0, 32'h3014, 1'b1, 1'b0, 1'b0);
        compared++; if (IF_BD !== 1'b1 || IF_PC !== 32'h3010) begin mismatched++; $display("FAIL bd_hold: got %h/%b want 00003010/1", IF_PC, IF_BD); end
        step(1'b0, 32'h3014, 1'b0, 1'b0, 1'b0);
        compared++; if (IF_BD !== 1'b0) begin mismatched++; $display("FAIL bd_clear: got %b want 0", IF_BD); end
    endtask

    task automatic test_addr_exc();
        logic [31:0] addrs [8] = '{32'h3002, 32'h7000, 32'h6FFC, 32'h2FFC,
                                   32'h3000, 32'hFFFF_FFFC, 32'h6FFD, 32'h0000_0000};
        for (int i = 0; i < 8; i++) begin
            step(1'b0, addrs[i], 1'b0, 1'b0, 1'b0);
            compared++;
            if (IF_PC !== addrs[i] || IF_Exc !== model_exc(addrs[i]) ||
                IF_ExcCode !== (model_exc(addrs[i]) ? 5'd4 : 5'd0)) begin
                mismatched++;
                $display("FAIL addr_exc[%h]: got pc %h exc %b code %0d want exc %b", addrs[i], IF_PC, IF_Exc, IF_ExcCode, model_exc(addrs[i]));
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 32'h3400, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h3404, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h3408, 1'b1, 1'b0, 1'b0);
        compared++; if (IF_PC !== 32'h3000 || IF_BD !== 1'b0 || State !== 2'd0) begin mismatched++; $display("FAIL reset_mid_stall: got %h/%b/%0d want 00003000/0/0", IF_PC, IF_BD, State); end
        step(1'b0, 32'h3400, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h3404, 1'b0, 1'b1, 1'b0);
        compared++; if (IF_PC !== 32'h3000 || State !== 2'd0) begin mismatched++; $display("FAIL reset_mid_exc: got %h/%0d want 00003000/0", IF_PC, State); end
`ifdef FETCH_PERF_CNT_EN
        compared++; if (Fetch_Cnt !== 0 || Stall_Cnt !== 0) begin mismatched++; $display("FAIL reset_mid_cnt: got %0d/%0d want 0/0", Fetch_Cnt, Stall_Cnt); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] npc;
        for (int i = 0; i < 400; i++) begin
            npc = ($urandom_range(0, 3) == 0) ? $urandom : (32'h3000 + ($urandom_range(0, 16'h1000) << 2));
            if ($urandom_range(0, 7) == 0) npc = npc | 32'h1;
            step($urandom_range(0, 39) == 0, npc, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
            compared++;
            if (IF_PC !== m_pc || IF_BD !== m_bd || State !== m_st ||
                IF_Exc !== model_exc(m_pc) || IF_ExcCode !== (model_exc(m_pc) ? 5'd4 : 5'd0)) begin
                mismatched++;
                $display("FAIL random[%0d]: got pc %h bd %b st %0d exc %b code %0d want pc %h bd %b st %0d exc %b",
                         i, IF_PC, IF_BD, State, IF_Exc, IF_ExcCode, m_pc, m_bd, m_st, model_exc(m_pc));
            end
`ifdef FETCH_PERF_CNT_EN
            compared++;
            if (Fetch_Cnt !== m_fc || Stall_Cnt !== m_sc) begin
                mismatched++;
                $display("FAIL random_cnt[%0d]: got %0d/%0d want %0d/%0d", i, Fetch_Cnt, Stall_Cnt, m_fc, m_sc);
            end
`endif
        end
    endtask

    initial begin
        reset = 1'b1; NPC = 32'h0; Stall_IF = 1'b0; Req = 1'b0; ID_Is_Jump = 1'b0;
        m_pc = 32'h3000; m_bd = 1'b0; m_st = 2'd0; m_fc = 0; m_sc = 0;
        #2;
        test_reset();
        test_stall();
        test_exc();
        test_delay_slot();
        test_addr_exc();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
